unified_mem_arbiter: RTL and testbench

Sequencer and arbiter that shares one single-ported unified instruction/data memory between the fetch path (IF) and the load/store path (DM) of the RISC-V core. It accepts one transaction per grant and tracks the single outstanding read through the fixed memory read latency. It returns read data to the requester that issued the read. Requesters see grant/valid handshakes and stall on their own until these arrive.

---
 rtl/unified_mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-ported unified instruction/data memory between the fetch
// path (IF, read-only) and the load/store path (DM). One transaction is
// accepted per grant. A granted read parks the sequencer in RD_WAIT for the
// fixed memory read latency and then raises rvalid for the requester that
// issued it. Writes complete at the accepting edge and never leave IDLE.
//
// Priority:
//   default            : DM wins. IF wins instead once DM has been granted
//                        MAX_STREAK times in a row while IF was waiting.
//   MEM_ARB_RR_EN      : define this macro for strict round-robin. On a tie
//                        the requester not granted last wins, and the
//                        starvation counter is removed.
//
// Parameters:
//   ADDR_W      address width
//   DATA_W      data width (multiple of 8)
//   RD_LAT      memory read latency in cycles (1..3)
//   MAX_STREAK  DM grants allowed in a row while IF waits (1..15)
//
// Ports:
//   clk, rst                   rising-edge clock, async active-high reset
//   if_req/if_addr             fetch read request
//   if_gnt/if_rvalid/if_rdata  fetch grant and read return
//   dm_req/dm_we/dm_be/
//   dm_addr/dm_wdata           load/store request
//   dm_gnt/dm_rvalid/dm_rdata  load/store grant and read return
//   mem_en/mem_we/mem_be/
//   mem_addr/mem_wdata         memory command (valid when mem_en)
//   mem_rdata                  memory read data, RD_LAT cycles after accept
//   busy                       a read is outstanding
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);
  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_DM   = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        lat_cnt_reg, lat_cnt_next;
  logic              owner_reg, owner_next;

  // Last command driven to memory; replayed on mem_* while nothing is granted.
  logic [ADDR_W-1:0] addr_hold_reg;
  logic [DATA_W-1:0] wdata_hold_reg;
  logic [BE_W-1:0]   be_hold_reg;

  logic              grant_ok;
  logic              if_wins;
  logic              rd_done;

  // Grants are purely combinational in IDLE. Gating with rst keeps every
  // grant (and therefore mem_en) low while reset is held.
  assign grant_ok = (state_reg == IDLE) && !rst;

`ifdef MEM_ARB_RR_EN
  // 1 = DM was granted last. Resetting to IF lets DM take the first tie.
  logic last_dm_reg;

  assign if_wins = if_req && (!dm_req || last_dm_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dm_reg <= 1'b0;
    end else if (if_gnt) begin
      last_dm_reg <= 1'b0;
    end else if (dm_gnt) begin
      last_dm_reg <= 1'b1;
    end
  end
`else
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic [3:0] streak_reg, streak_next;

  // IF only overrides DM once the streak has saturated.
  assign if_wins = if_req && (!dm_req || (streak_reg == STREAK_MAX));

  always_comb begin
    streak_next = streak_reg;
    if (!if_req || if_gnt) begin
      streak_next = 4'd0;
    end else if (dm_gnt && (streak_reg != STREAK_MAX)) begin
      streak_next = streak_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_reg <= 4'd0;
    end else begin
      streak_reg <= streak_next;
    end
  end
`endif

  assign if_gnt = grant_ok && if_wins;
  assign dm_gnt = grant_ok && dm_req && !if_wins;

  // Memory command mux. IF is always a full-word read; when nobody is
  // granted the previous command fields are held to avoid needless toggling.
  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_be    = be_hold_reg;
    mem_addr  = addr_hold_reg;
    mem_wdata = wdata_hold_reg;
    if (if_gnt) begin
      mem_be   = '1;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_be    = dm_be;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      be_hold_reg    <= '0;
      addr_hold_reg  <= '0;
      wdata_hold_reg <= '0;
    end else if (mem_en) begin
      be_hold_reg    <= mem_be;
      addr_hold_reg  <= mem_addr;
      wdata_hold_reg <= mem_wdata;
    end
  end

  // Read return: memory data is simply passed through; only rvalid is steered.
  assign rd_done   = (state_reg == RD_WAIT) && (lat_cnt_reg == 2'd0);
  assign if_rvalid = rd_done && (owner_reg == OWN_IF);
  assign dm_rvalid = rd_done && (owner_reg == OWN_DM);
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign busy      = (state_reg == RD_WAIT);

  // Sequencer next state.
  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    owner_next   = owner_reg;
    case (state_reg)
      IDLE: begin
        if (mem_en && !mem_we) begin
          state_next   = RD_WAIT;
          lat_cnt_next = LAT_LOAD;
          owner_next   = dm_gnt ? OWN_DM : OWN_IF;
        end
      end
      RD_WAIT: begin
        if (lat_cnt_reg == 2'd0) begin
          state_next = IDLE;
        end else begin
          lat_cnt_next = lat_cnt_reg - 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // An asserted reset drops any outstanding read immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      lat_cnt_reg <= 2'd0;
      owner_reg   <= OWN_IF;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
      owner_reg   <= owner_next;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
`timescale 1ns/1ps
// Bench for unified_mem_arbiter (RD_LAT=2, MAX_STREAK=4). Stimulus pushes the
// expected grant/return events into a scoreboard queue; a negedge monitor
// pops and compares each event the DUT presents.
module tb_unified_mem_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int BW         = DW / 8;
  localparam int RD_LAT     = 2;
  localparam int MAX_STREAK = 4;

  localparam int K_DMW = 0;
  localparam int K_DMR = 1;
  localparam int K_IFG = 2;
  localparam int K_DRV = 3;
  localparam int K_IRV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [BW-1:0] dm_be = '0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_en, mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    int         kind;
    logic [31:0] val;
    logic [4:0]  ctl;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: word array, byte-enabled writes, RD_LAT-deep read pipe.
  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [0:RD_LAT-1];

  assign mem_rdata = rd_pipe[RD_LAT-1];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    if (mem_en && !mem_we) rd_pipe[0] <= mem[mem_addr[9:2]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  function automatic string kname(input int k);
    case (k)
      K_DMW:   return "dm_write_gnt";
      K_DMR:   return "dm_read_gnt";
      K_IFG:   return "if_gnt";
      K_DRV:   return "dm_rvalid";
      K_IRV:   return "if_rvalid";
      default: return "none";
    endcase
  endfunction

  task automatic push(input int c, input int k, input logic [31:0] v, input logic [4:0] ctl);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.ctl = ctl;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dm(input logic req, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    dm_req = req; dm_we = we; dm_addr = a; dm_wdata = d; dm_be = be;
  endtask

  // Monitor: at most one grant/return event can occur per cycle.
  always @(negedge clk) begin
    int          obs;
    int          nsig;
    logic [31:0] val;
    logic [4:0]  ctl;
    exp_t        e;
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missing_%s: got nothing expected event at cycle %0d (now %0d)",
                 kname(e.kind), e.cyc, cyc);
      end
      checks++;
      if (mem_en !== (if_gnt | dm_gnt)) begin
        errors++;
        $display("FAIL mem_en: got %0b expected %0b (cycle %0d)", mem_en, if_gnt | dm_gnt, cyc);
      end
      nsig = int'(if_gnt) + int'(dm_gnt) + int'(if_rvalid) + int'(dm_rvalid);
      obs = -1; val = '0; ctl = '0;
      if (dm_gnt) begin
        obs = dm_we ? K_DMW : K_DMR; val = mem_addr; ctl = {mem_we, mem_be};
      end else if (if_gnt) begin
        obs = K_IFG; val = mem_addr; ctl = {mem_we, mem_be};
      end else if (dm_rvalid) begin
        obs = K_DRV; val = dm_rdata;
      end else if (if_rvalid) begin
        obs = K_IRV; val = if_rdata;
      end
      if (nsig > 1) begin
        checks++; errors++;
        $display("FAIL multi_event: got %0d events expected at most 1 (cycle %0d)", nsig, cyc);
      end
      if (obs >= 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_%s: got val 0x%08h expected no event (cycle %0d)",
                   kname(obs), val, cyc);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.kind != obs || e.val !== val || e.ctl !== ctl) begin
            errors++;
            $display("FAIL %s: got %s val 0x%08h ctl 0x%02h at cycle %0d expected %s val 0x%08h ctl 0x%02h at cycle %0d",
                     kname(e.kind), kname(obs), val, ctl, cyc, kname(e.kind), e.val, e.ctl, e.cyc);
          end else begin
            $display("cycle %0d %s val 0x%08h ctl 0x%02h ok", cyc, kname(obs), val, ctl);
          end
        end
      end
    end
  end

  initial begin
    int t;
    int k;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    mem[16] = 32'hDEAD_BEEF;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

    // Reset held with both requests present.
    #1 rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h4;
    set_dm(1'b1, 1'b1, 32'h200, 32'h55, 4'hF);
    tick(); tick();
    chk("rst_if_gnt",    {31'd0, if_gnt},    32'd0);
    chk("rst_dm_gnt",    {31'd0, dm_gnt},    32'd0);
    chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
    chk("rst_mem_en",    {31'd0, mem_en},    32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_mem_be",    {28'd0, mem_be},    32'd0);
    chk("rst_mem_addr",  mem_addr,           32'd0);
    chk("rst_mem_wdata", mem_wdata,          32'd0);

    // Release: DM wins the first cycle, IF follows.
    rst = 1'b0;
    t = cyc;
    push(t,     K_DMW, 32'h200, 5'b1_1111);
    push(t + 1, K_IFG, 32'h4,   5'b0_1111);
    push(t + 3, K_IRV, 32'h1000_0001, 5'b0);
    tick(); dm_req = 1'b0;
    tick(); if_req = 1'b0;
    tick(); tick();
    chk("idle_mem_en",   {31'd0, mem_en}, 32'd0);
    chk("idle_hold_addr", mem_addr, 32'h4);

    // Simultaneous IF read 0x0 and DM write 0x100.
    t = cyc;
    if_req = 1'b1; if_addr = 32'h0;
    set_dm(1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF);
    push(t,     K_DMW, 32'h100, 5'b1_1111);
    push(t + 1, K_IFG, 32'h0,   5'b0_1111);
    push(t + 3, K_IRV, 32'h1000_0000, 5'b0);
    tick(); dm_req = 1'b0;
    tick(); if_req = 1'b0;
    tick(); tick();

    // Partial byte-enable write, then read it back.
    t = cyc;
    set_dm(1'b1, 1'b1, 32'h100, 32'h1111_2222, 4'h3);
    push(t,     K_DMW, 32'h100, 5'b1_0011);
    push(t + 1, K_DMR, 32'h100, 5'b0_1111);
    push(t + 3, K_DRV, 32'hCAFE_2222, 5'b0);
    tick(); set_dm(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
    tick(); dm_req = 1'b0;
    tick(); tick();

    // Read latency: DM load 0x40; an IF request during RD_WAIT must wait.
    t = cyc;
    set_dm(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    push(t,     K_DMR, 32'h40, 5'b0_1111);
    push(t + 2, K_DRV, 32'hDEAD_BEEF, 5'b0);
    push(t + 3, K_IFG, 32'h8, 5'b0_1111);
    push(t + 5, K_IRV, 32'h1000_0002, 5'b0);
    tick(); dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h8;
    chk("rdwait_busy1", {31'd0, busy}, 32'd1);
    tick();
    chk("rdwait_busy2", {31'd0, busy}, 32'd1);
    tick();
    chk("after_rd_busy", {31'd0, busy}, 32'd0);
    tick(); if_req = 1'b0;
    tick(); tick();

    // Reset during RD_WAIT: the DM read is dropped, pending IF served on release.
    t = cyc;
    set_dm(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
    push(t, K_DMR, 32'h44, 5'b0_1111);
    tick(); dm_req = 1'b0; rst = 1'b1; if_req = 1'b1; if_addr = 32'hC;
    #1;
    chk("midrst_busy",    {31'd0, busy},      32'd0);
    chk("midrst_dm_rval", {31'd0, dm_rvalid}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    t = cyc;
    push(t,     K_IFG, 32'hC, 5'b0_1111);
    push(t + 2, K_IRV, 32'h1000_0003, 5'b0);
    tick(); if_req = 1'b0;
    tick(); tick(); tick();

`ifdef MEM_ARB_RR_EN
    // Round-robin: grants alternate DM, IF, DM, IF, DM.
    t = cyc;
    push(t,     K_DMW, 32'h180, 5'b1_1111);
    push(t + 1, K_IFG, 32'h10,  5'b0_1111);
    push(t + 3, K_IRV, 32'h1000_0004, 5'b0);
    push(t + 4, K_DMW, 32'h184, 5'b1_1111);
    push(t + 5, K_IFG, 32'h14,  5'b0_1111);
    push(t + 7, K_IRV, 32'h1000_0005, 5'b0);
    push(t + 8, K_DMW, 32'h188, 5'b1_1111);
    for (int c = 0; c <= 8; c++) begin
      k = (c == 0) ? 0 : ((c <= 4) ? 1 : 2);
      set_dm(1'b1, 1'b1, 32'h180 + 32'(4 * k), 32'hA0 + 32'(k), 4'hF);
      if_req  = (c <= 5);
      if_addr = (c <= 1) ? 32'h10 : 32'h14;
      tick();
    end
    dm_req = 1'b0; if_req = 1'b0;
`else
    // Starvation guard: 4 DM grants, then IF, then DM resumes.
    t = cyc;
    for (int i = 0; i < 4; i++) push(t + i, K_DMW, 32'h180 + 32'(4 * i), 5'b1_1111);
    push(t + 4, K_IFG, 32'h10, 5'b0_1111);
    push(t + 6, K_IRV, 32'h1000_0004, 5'b0);
    push(t + 7, K_DMW, 32'h190, 5'b1_1111);
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 0; c <= 7; c++) begin
      k = (c < 4) ? c : 4;
      set_dm(1'b1, 1'b1, 32'h180 + 32'(4 * k), 32'hA0 + 32'(k), 4'hF);
      if (c == 5) if_req = 1'b0;
      tick();
    end
    dm_req = 1'b0;
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending events expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
